// File: rtl/mem_2r1w_pkg.sv
// Shared core definitions: the default data width and the byte-address to
// word-index mapping used by the register file and the data memory.
package mem_2r1w_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;

    // Word index of a byte address: drop the byte offset and keep idx_w bits.
    function automatic logic [ADDR_W-1:0] addr_to_index(
        input logic [ADDR_W-1:0] addr,
        input int unsigned       idx_w
    );
        return (addr >> 2) & ((ADDR_W'(1) << idx_w) - ADDR_W'(1));
    endfunction

endpackage

// File: rtl/mem_2r1w.sv
// Two-read, one-write flop-array memory with combinational reads and an
// asynchronous active-low clear of every word.
module mem_2r1w
    import mem_2r1w_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr0,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] wr_addr0,
    input  logic [WIDTH-1:0]  wr_din0,
    input  logic              we0,
    output logic [WIDTH-1:0]  rd_dout0,
    output logic [WIDTH-1:0]  rd_dout1
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic [IDX_W-1:0] rd_idx0_c;
    logic [IDX_W-1:0] rd_idx1_c;
    logic [IDX_W-1:0] wr_idx0_c;

    assign rd_idx0_c = IDX_W'(addr_to_index(rd_addr0, IDX_W));
    assign rd_idx1_c = IDX_W'(addr_to_index(rd_addr1, IDX_W));
    assign wr_idx0_c = IDX_W'(addr_to_index(wr_addr0, IDX_W));

    // Next-state of the array: only the addressed word changes on a write.
    always_comb begin
        mem_d = mem_q;
        if (we0) begin
            mem_d[wr_idx0_c] = wr_din0;
        end
    end

    // Reset clears the whole array in parallel, independent of clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Independent DEPTH:1 read muxes; no write-to-read bypass.
    assign rd_dout0 = mem_q[rd_idx0_c];
    assign rd_dout1 = mem_q[rd_idx1_c];

endmodule

// File: tb/tb_mem_2r1w.sv
// Self-checking bench for mem_2r1w: directed scenarios plus randomized
// traffic compared against an array model of the memory.
module tb_mem_2r1w;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             rst;
    logic [31:0]      rd_addr0;
    logic [31:0]      rd_addr1;
    logic [31:0]      wr_addr0;
    logic [WIDTH-1:0] wr_din0;
    logic             we0;
    logic [WIDTH-1:0] rd_dout0;
    logic [WIDTH-1:0] rd_dout1;

    logic [WIDTH-1:0] model [DEPTH];
    int unsigned      n_vec;
    int unsigned      n_err;

    mem_2r1w #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr0 (rd_addr0),
        .rd_addr1 (rd_addr1),
        .wr_addr0 (wr_addr0),
        .wr_din0  (wr_din0),
        .we0      (we0),
        .rd_dout0 (rd_dout0),
        .rd_dout1 (rd_dout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int word_of(input logic [31:0] addr);
        return int'((addr / 32'd4) % DEPTH);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
    endtask

    // Write through port 0 over one rising edge, keeping the model in step.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        we0      = 1'b1;
        wr_addr0 = addr;
        wr_din0  = data;
        @(posedge clk);
        if (rst) model[word_of(addr)] = data;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b0;
        we0      = 1'b0;
        rd_addr0 = '0;
        rd_addr1 = '0;
        wr_addr0 = '0;
        wr_din0  = '0;
        clear_model();

        // Reset: outputs read zero and a write under reset is dropped.
        @(negedge clk);
        rd_addr0 = 32'd0;
        rd_addr1 = 32'd60;
        #1;
        check("rst_rd0", rd_dout0, 32'h0);
        check("rst_rd1", rd_dout1, 32'h0);
        do_write(32'd0, 32'hFFFF_FFFF);
        @(negedge clk);
        we0 = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_write_dropped", rd_dout0, model[0]);

        // Fill every word with its own index.
        for (int i = 0; i < int'(DEPTH); i++) do_write(32'(4 * i), 32'(i));
        @(negedge clk);
        we0 = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            rd_addr0 = 32'(4 * i);
            rd_addr1 = 32'(4 * i);
            #1;
            check("fill_rd0", rd_dout0, 32'(i));
            check("fill_rd1", rd_dout1, 32'(i));
        end

        // Unaligned and wrapping addresses.
        rd_addr0 = 32'd0;
        rd_addr1 = 32'd1;
        #1;
        check("alias_rd0_a0", rd_dout0, 32'd0);
        check("alias_rd1_a1", rd_dout1, 32'd0);
        rd_addr1 = 32'd66;
        #1;
        check("wrap_rd1_a66", rd_dout1, 32'd0);
        rd_addr0 = 32'd7;
        #1;
        check("alias_rd0_a7", rd_dout0, 32'd1);

        // Read during write: old data before the edge, new data after.
        @(negedge clk);
        we0      = 1'b1;
        wr_addr0 = 32'd8;
        wr_din0  = 32'hA5A5_A5A5;
        rd_addr0 = 32'd8;
        #1;
        check("rdw_before", rd_dout0, 32'd2);
        @(posedge clk);
        model[2] = 32'hA5A5_A5A5;
        #1;
        check("rdw_after", rd_dout0, 32'hA5A5_A5A5);

        // Hold with write enable low.
        @(negedge clk);
        we0      = 1'b0;
        wr_addr0 = 32'd12;
        wr_din0  = 32'hDEAD_BEEF;
        rd_addr1 = 32'd12;
        repeat (3) @(posedge clk);
        #1;
        check("hold_a12", rd_dout1, 32'd3);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            we0      = 1'($urandom_range(0, 1));
            wr_addr0 = $urandom;
            wr_din0  = $urandom;
            rd_addr0 = ($urandom_range(0, 3) == 0) ? wr_addr0 : $urandom;
            rd_addr1 = ($urandom_range(0, 3) == 0) ? rd_addr0 : $urandom;
            #1;
            check("rand_rd0", rd_dout0, model[word_of(rd_addr0)]);
            check("rand_rd1", rd_dout1, model[word_of(rd_addr1)]);
            @(posedge clk);
            if (we0) model[word_of(wr_addr0)] = wr_din0;
        end

        // Mid-run async reset between edges clears everything at once.
        @(negedge clk);
        we0 = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) do_write(32'(4 * i), 32'(i + 100));
        @(negedge clk);
        we0      = 1'b0;
        rd_addr0 = 32'd20;
        rd_addr1 = 32'd40;
        #1;
        check("pre_reset_rd0", rd_dout0, 32'd105);
        rst = 1'b0;
        clear_model();
        #1;
        check("async_rst_rd0", rd_dout0, 32'd0);
        check("async_rst_rd1", rd_dout1, 32'd0);
        #1;
        rst = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            rd_addr0 = 32'(4 * i);
            rd_addr1 = 32'(4 * i + 2);
            #1;
            check("cleared_rd0", rd_dout0, model[i]);
            check("cleared_rd1", rd_dout1, model[i]);
        end

        // Writes resume right after reset release.
        do_write(32'd36, 32'h1234_5678);
        @(negedge clk);
        we0      = 1'b0;
        rd_addr0 = 32'd36;
        #1;
        check("post_rst_write", rd_dout0, 32'h1234_5678);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_2r1w.md
MEM_2R1W -- requirements
Module: mem_2r1w

Interface
REQ-001 Parameter DEPTH, default 16: number of 32-bit words; a power of two, at least 2.
REQ-002 Parameter WIDTH, default 32: data word width in bits.
REQ-003 Derived constant IDX_W = log2(DEPTH): word-index width.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 rd_addr0  input  32  byte address, read port 0.
REQ-007 rd_addr1  input  32  byte address, read port 1.
REQ-008 wr_addr0  input  32  byte address, write port 0.
REQ-009 wr_din0  input  WIDTH  write data.
REQ-010 we0  input  1  write enable, active-high.
REQ-011 rd_dout0  output  WIDTH  read data, port 0.
REQ-012 rd_dout1  output  WIDTH  read data, port 1.

Function
REQ-013 Storage SHALL be DEPTH words of WIDTH bits each.
REQ-014 Word index SHALL be addr[IDX_W+1:2] on every port; bits [1:0] are ignored, with no alignment fault.
REQ-015 Address bits above IDX_W+1 SHALL be ignored, so addresses wrap modulo DEPTH*4.
REQ-016 Write: when rst=1 and we0=1 at a rising clk edge, mem[wr index] SHALL take wr_din0.
REQ-017 Writes SHALL have one-cycle latency: the new data is visible on reads after the edge.
REQ-018 When we0=0, memory SHALL hold its contents.
REQ-019 Reads SHALL be combinational, with zero latency: rd_doutN = mem[rd index N] and follows address changes within the same cycle.
REQ-020 The two read ports SHALL be independent; both may address the same word and SHALL return identical data.
REQ-021 Read of the address being written in the same cycle SHALL return the old contents until the clock edge; there is no write-to-read bypass.
REQ-022 No handshake, no stall, no error outputs.

Reset
REQ-023 While rst=0, every memory word SHALL be cleared to 0 asynchronously.
REQ-024 While rst=0, both read outputs SHALL read 0.
REQ-025 A write presented while rst=0 SHALL be discarded.
REQ-026 On rst deassertion, the memory SHALL accept writes from the next rising edge.
REQ-027 Assertion of reset mid-operation SHALL clear all contents immediately, without waiting for clk.

Structure
REQ-028 The address-to-index function (addr[IDX_W+1:2]) SHALL be defined once in the shared core package, for reuse by the register file and data memory.
REQ-029 The default WIDTH constant (32) SHALL also be defined in that package.
REQ-030 The block SHALL be a single module with no sub-modules; storage is a flip-flop array with an async-clear reset, which makes async reads and parallel reset possible.
REQ-031 Each read path SHALL be a DEPTH:1 mux.

Verification
REQ-032 Reset: with rst=0, apply rd_addr0=0 and rd_addr1=60 -> both outputs read 0; then write 0xFFFF_FFFF with rst=0 -> the word still reads 0 after release.
REQ-033 Fill: rst=1, we0=1; for i=0..15 drive wr_addr0=4*i, wr_din0=i, one per clk edge; then we0=0 -> reading addr 4*i returns i on both ports.
REQ-034 Unaligned/alias: after the fill, rd_addr0=0 and rd_addr1=1 -> both read 0; rd_addr1=66 -> reads 16 words' index 0 wrap... reads 0 (index 0); rd_addr0=7 -> reads 1.
REQ-035 Read-during-write: with mem[2]=2, drive we0=1, wr_addr0=8, wr_din0=0xA5A5_A5A5 and rd_addr0=8 -> reads 2 before the edge and 0xA5A5_A5A5 after it.
REQ-036 Hold: we0=0, wr_din0=0xDEAD_BEEF, wr_addr0=12 for 3 cycles -> addr 12 still reads 3.
REQ-037 Async reset mid-run: after the fill, pulse rst=0 between clock edges -> all 16 words read 0 immediately, without waiting for clk.
